// File: rtl/word_serial_ctrl.sv
// word_serial_ctrl: sequencing controller for the word-cluster datapath.
//
// Accepts one BUS_WIDTH bus word over a valid/ready handshake and presents its
// WORDS sub-words on word_bus, most significant first, one per cycle. The
// datapath error flag is sampled alongside each word. Each bus word ends with
// a one-cycle done pulse that carries an OR-ed error status. After ERR_MAX
// consecutive failed bus words the controller halts until reset.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   data_in, valid_in    bus word and its valid (source holds until accepted)
//   ready_out            controller accepts data_in this cycle
//   word_bus, word_valid current word to the datapath (zero when not valid)
//   word_err             datapath error for the word currently on word_bus
//   data_out             last completed bus word, held until next completion
//   done, word_fail      completion pulse and its error status
//   err_count            consecutive failed bus word count (saturating)
//   error                sticky halt flag
//
// Every output is a register, so there is no combinational input-to-output path.
module word_serial_ctrl #(
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned WORDS      = 4,
  parameter int unsigned ERR_MAX    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BUS_WIDTH-1:0]  data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [WORD_WIDTH-1:0] word_bus,
  output logic                  word_valid,
  input  logic                  word_err,
  output logic [BUS_WIDTH-1:0]  data_out,
  output logic                  done,
  output logic                  word_fail,
  output logic [2:0]            err_count,
  output logic                  error
);

  localparam int unsigned   IdxW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(WORDS - 1);
  localparam logic [2:0]    ErrMax  = 3'(ERR_MAX);

  typedef enum logic [1:0] {StIdle, StSend, StDone, StHalt} state_e;

  state_e               state_q;
  logic [BUS_WIDTH-1:0] shreg_q;
  logic [IdxW-1:0]      index_q;
  logic                 fail_acc_q;

  logic                  load;
  logic                  fail_now;
  logic [2:0]            err_next;
  logic [IdxW-1:0]       index_dec;
  logic [WORD_WIDTH-1:0] first_word;
  logic [WORD_WIDTH-1:0] next_word;

  always_comb begin
    // ready_out is only ever high in IDLE or in a non-halting DONE cycle.
    load       = valid_in && ready_out;
    fail_now   = fail_acc_q | word_err;
    err_next   = fail_now ? ((err_count == ErrMax) ? ErrMax : err_count + 3'd1) : 3'd0;
    index_dec  = index_q - IdxW'(1);
    first_word = data_in[BUS_WIDTH-1 -: WORD_WIDTH];
    next_word  = shreg_q[int'(index_dec) * WORD_WIDTH +: WORD_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      index_q    <= IdxLast;
      fail_acc_q <= 1'b0;
      ready_out  <= 1'b1;
      word_bus   <= '0;
      word_valid <= 1'b0;
      data_out   <= '0;
      done       <= 1'b0;
      word_fail  <= 1'b0;
      err_count  <= 3'd0;
      error      <= 1'b0;
    end else begin
      // Pulse-style outputs default low; word_bus is zero whenever not valid.
      done       <= 1'b0;
      word_fail  <= 1'b0;
      word_valid <= 1'b0;
      word_bus   <= '0;

      unique case (state_q)
        StIdle, StDone: begin
          if (state_q == StDone && err_count == ErrMax) begin
            state_q   <= StHalt;
            error     <= 1'b1;
            ready_out <= 1'b0;
          end else if (load) begin
            // First word goes out the cycle after the accept edge.
            shreg_q    <= data_in;
            index_q    <= IdxLast;
            fail_acc_q <= 1'b0;
            state_q    <= StSend;
            ready_out  <= 1'b0;
            word_valid <= 1'b1;
            word_bus   <= first_word;
          end else begin
            state_q   <= StIdle;
            ready_out <= 1'b1;
          end
        end

        StSend: begin
          fail_acc_q <= fail_now;
          if (index_q == '0) begin
            state_q   <= StDone;
            done      <= 1'b1;
            word_fail <= fail_now;
            data_out  <= shreg_q;
            err_count <= err_next;
            // Reaching the limit blocks the DONE-cycle accept.
            ready_out <= (err_next != ErrMax);
          end else begin
            index_q    <= index_dec;
            word_valid <= 1'b1;
            word_bus   <= next_word;
          end
        end

        StHalt: begin
          // Sticky until reset; data_out and err_count hold.
        end

        default: begin
          state_q   <= StIdle;
          ready_out <= 1'b1;
        end
      endcase
    end
  end

endmodule
